// File: rtl/otg_bus_responder_if.sv
//==============================================================================
// Module   : otg_bus_responder_if
// Brief    : OTG host bus signal bundle (host drives master, responder is slave)
// Revision : 1.0
//==============================================================================
`default_nettype none

interface otg_bus_responder_if;
    logic [1:0]  OTG_ADDR;
    logic        OTG_CS_N;
    logic        OTG_RD_N;
    logic        OTG_WR_N;
    logic [15:0] OTG_DATA_IN;
    logic [15:0] OTG_DATA_OUT;
    logic        OTG_DATA_OE;
    logic        OTG_INT0;
    logic        OTG_INT1;

    modport master (
        output OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_DATA_IN,
        input  OTG_DATA_OUT, OTG_DATA_OE, OTG_INT0, OTG_INT1
    );

    modport slave (
        input  OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_DATA_IN,
        output OTG_DATA_OUT, OTG_DATA_OE, OTG_INT0, OTG_INT1
    );
endinterface

`default_nettype wire

// File: rtl/otg_bus_responder.sv
//==============================================================================
// Module   : otg_bus_responder
// Brief    : Two-bank 32-bit register port answering 16-bit OTG host bus cycles
// Revision : 1.0
//==============================================================================
`default_nettype none

module otg_bus_responder #(
    parameter int IDX_W       = 5,
    parameter int IRQ_IDX     = 5'h1F,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             iCLK,
    input  wire logic             iRST,
    otg_bus_responder_if.slave    bus,
    input  wire logic [1:0]       iEVT,
    output logic                  oREG_WE,
    output logic                  oREG_BANK,
    output logic [IDX_W-1:0]      oREG_IDX,
    output logic [31:0]           oREG_WDATA,
    output logic                  oERR
);

    localparam int NREG = 2 ** IDX_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic rd_act, wr_act, act, act_q, rd_act_q, ending;
    logic seen_wr, seen_both;
    logic [1:0]  cap_addr;
    logic [15:0] cap_data;

    logic             bank, oor;
    logic [IDX_W-1:0] idx;
    logic [4:0]       idx5;
    logic [15:0]      lo;
    logic [31:0]      rdbuf;
    logic [1:0]       pend, pend_nx;
    logic [15:0]      dout, rd_value;
    logic [31:0]      regs [2][NREG];

    logic             cmd_oor, cmd_hit, cur_hit;
    logic [IDX_W-1:0] cmd_idx;
    logic             do_cmd, do_lo, do_commit, do_err;

    // Strobes idle high so a reset never looks like the start of an access
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus.OTG_CS_N};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.OTG_RD_N};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.OTG_WR_N};
        end
    end

    assign rd_act = !cs_sync[SYNC_STAGES-1] && !rd_sync[SYNC_STAGES-1];
    assign wr_act = !cs_sync[SYNC_STAGES-1] && !wr_sync[SYNC_STAGES-1];
    assign act    = rd_act || wr_act;
    assign ending = act_q && !act;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            act_q     <= 1'b0;
            rd_act_q  <= 1'b0;
            seen_wr   <= 1'b0;
            seen_both <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
        end else begin
            act_q    <= act;
            rd_act_q <= rd_act;
            if (act) begin
                cap_addr  <= bus.OTG_ADDR;
                seen_wr   <= seen_wr || wr_act;
                seen_both <= seen_both || (rd_act && wr_act);
            end else begin
                seen_wr   <= 1'b0;
                seen_both <= 1'b0;
            end
            if (wr_act)
                cap_data <= bus.OTG_DATA_IN;
        end
    end

    assign cmd_idx = cap_data[IDX_W-1:0];
    assign cmd_oor = |cap_data[6:IDX_W];
    assign cmd_hit = !cmd_oor && (cmd_idx == IRQ_IDX[IDX_W-1:0]);
    assign cur_hit = (idx == IRQ_IDX[IDX_W-1:0]);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Everything is decided on the trailing edge of an access
    always_comb begin
        state_nx  = state;
        do_cmd    = 1'b0;
        do_lo     = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        if (ending) begin
            if (seen_both) begin
                do_err = 1'b1;
            end else if (seen_wr) begin
                if (cap_addr[0]) begin
                    do_cmd   = 1'b1;
                    state_nx = cap_data[7] ? WR_LO : RD_LO;
                end else begin
                    case (state)
                        WR_LO:   begin do_lo = 1'b1;     state_nx = WR_HI; end
                        WR_HI:   begin do_commit = 1'b1; state_nx = IDLE;  end
                        default: do_err = 1'b1;
                    endcase
                end
            end else if (!cap_addr[0]) begin
                case (state)
                    RD_LO:   state_nx = RD_HI;
                    RD_HI:   state_nx = IDLE;
                    default: do_err = 1'b1;
                endcase
            end
        end
    end

    // Event set overrides a read-clear landing in the same cycle
    always_comb begin
        pend_nx = pend;
        if (do_cmd && !cap_data[7] && cmd_hit)
            pend_nx[cap_addr[1]] = 1'b0;
        pend_nx = pend_nx | iEVT;
    end

    always_comb begin
        idx5           = '0;
        idx5[IDX_W-1:0] = idx;
        if (bus.OTG_ADDR[0])
            rd_value = {6'b0, state, bank, 1'b0, idx5};
        else if (state == RD_LO)
            rd_value = rdbuf[15:0];
        else if (state == RD_HI)
            rd_value = rdbuf[31:16];
        else
            rd_value = 16'h0000;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bank       <= 1'b0;
            idx        <= '0;
            oor        <= 1'b0;
            lo         <= '0;
            rdbuf      <= '0;
            pend       <= '0;
            dout       <= '0;
            oREG_WE    <= 1'b0;
            oREG_BANK  <= 1'b0;
            oREG_IDX   <= '0;
            oREG_WDATA <= '0;
            oERR       <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NREG; i++)
                    regs[b][i] <= '0;
        end else begin
            oREG_WE <= 1'b0;
            oERR    <= do_err;
            pend    <= pend_nx;
            if (rd_act)
                dout <= rd_value;
            if (do_cmd) begin
                bank <= cap_addr[1];
                idx  <= cmd_idx;
                oor  <= cmd_oor;
                if (!cap_data[7]) begin
                    if (cmd_oor)
                        rdbuf <= '0;
                    else if (cmd_hit)
                        rdbuf <= {31'b0, pend[cap_addr[1]]};
                    else
                        rdbuf <= regs[cap_addr[1]][cmd_idx];
                end
            end
            if (do_lo)
                lo <= cap_data;
            if (do_commit && !oor) begin
                oREG_WE    <= 1'b1;
                oREG_BANK  <= bank;
                oREG_IDX   <= idx;
                oREG_WDATA <= {cap_data, lo};
                if (!cur_hit)
                    regs[bank][idx] <= {cap_data, lo};
            end
        end
    end

    assign bus.OTG_DATA_OE  = rd_act || rd_act_q;
    assign bus.OTG_DATA_OUT = bus.OTG_DATA_OE ? dout : 16'h0000;
    assign bus.OTG_INT0     = pend[0];
    assign bus.OTG_INT1     = pend[1];

endmodule

`default_nettype wire

// File: tb/tb_otg_bus_responder.sv
//==============================================================================
// Module   : tb_otg_bus_responder
// Brief    : Directed self-checking bench for otg_bus_responder
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_otg_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [15:0] din = 16'h0000;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        tgt = 1'b0;
    logic [1:0]  evt5 = 2'b00, evt4 = 2'b00;

    logic        we5, bank5, err5, we4, bank4, err4;
    logic [4:0]  idx5;
    logic [3:0]  idx4;
    logic [31:0] wdata5, wdata4;

    int n_checks = 0, n_fail = 0;
    int we5_cnt = 0, err5_cnt = 0, we4_cnt = 0;
    logic        last_bank5;
    logic [4:0]  last_idx5;
    logic [31:0] last_wdata5;
    logic [15:0] rv;

    always #5 clk = ~clk;

    otg_bus_responder_if b5 ();
    otg_bus_responder_if b4 ();

    assign b5.OTG_ADDR    = addr;
    assign b5.OTG_DATA_IN = din;
    assign b5.OTG_CS_N    = tgt ? 1'b1 : cs_n;
    assign b5.OTG_RD_N    = rd_n;
    assign b5.OTG_WR_N    = wr_n;
    assign b4.OTG_ADDR    = addr;
    assign b4.OTG_DATA_IN = din;
    assign b4.OTG_CS_N    = tgt ? cs_n : 1'b1;
    assign b4.OTG_RD_N    = rd_n;
    assign b4.OTG_WR_N    = wr_n;

    otg_bus_responder dut5 (
        .iCLK(clk), .iRST(rst), .bus(b5), .iEVT(evt5),
        .oREG_WE(we5), .oREG_BANK(bank5), .oREG_IDX(idx5),
        .oREG_WDATA(wdata5), .oERR(err5)
    );

    otg_bus_responder #(.IDX_W(4), .IRQ_IDX(15)) dut4 (
        .iCLK(clk), .iRST(rst), .bus(b4), .iEVT(evt4),
        .oREG_WE(we4), .oREG_BANK(bank4), .oREG_IDX(idx4),
        .oREG_WDATA(wdata4), .oERR(err4)
    );

    always @(posedge clk) begin
        if (we5) begin
            we5_cnt++;
            last_bank5  = bank5;
            last_idx5   = idx5;
            last_wdata5 = wdata5;
        end
        if (err5) err5_cnt++;
        if (we4)  we4_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d, input bit evt_at_commit = 1'b0);
        @(posedge clk); #1;
        addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        repeat (6) @(posedge clk);
        #1; cs_n = 1'b1; wr_n = 1'b1;
        if (evt_at_commit) begin
            // two sync stages later the trailing edge is seen; the event lands on that commit
            @(posedge clk); @(posedge clk); #1 evt5 = 2'b01;
            @(posedge clk); #1 evt5 = 2'b00;
            repeat (2) @(posedge clk);
        end else begin
            repeat (5) @(posedge clk);
        end
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        d = tgt ? b4.OTG_DATA_OUT : b5.OTG_DATA_OUT;
        @(posedge clk); #1;
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        check("rst_oe", {31'b0, b5.OTG_DATA_OE}, 32'd0);
        check("rst_int0", {31'b0, b5.OTG_INT0}, 32'd0);
        bus_rd(2'b01, rv); check("rst_status", {16'b0, rv}, 32'h0000);

        // Write sequence bank0 idx5
        bus_wr(2'b01, 16'h0085);
        bus_rd(2'b01, rv); check("wr_lo_status", {16'b0, rv}, 32'h0085);
        bus_wr(2'b00, 16'h1234);
        bus_wr(2'b00, 16'hABCD);
        check("we_count", we5_cnt, 1);
        check("we_idx", {27'b0, last_idx5}, 32'd5);
        check("we_bank", {31'b0, last_bank5}, 32'd0);
        check("we_wdata", last_wdata5, 32'hABCD1234);

        // Readback
        bus_wr(2'b01, 16'h0005);
        bus_rd(2'b01, rv); check("rd_lo_status", {16'b0, rv}, 32'h0185);
        bus_rd(2'b00, rv); check("rd_lo", {16'b0, rv}, 32'h1234);
        bus_rd(2'b00, rv); check("rd_hi", {16'b0, rv}, 32'hABCD);
        bus_rd(2'b01, rv); check("rd_end_status", {16'b0, rv}, 32'h0005);

        // Bank isolation
        bus_wr(2'b11, 16'h0085);
        bus_wr(2'b00, 16'h0001);
        bus_wr(2'b00, 16'h0000);
        check("b1_we_bank", {31'b0, last_bank5}, 32'd1);
        check("b1_we_wdata", last_wdata5, 32'h00000001);
        bus_wr(2'b01, 16'h0005);
        bus_rd(2'b00, rv); check("b0_iso_lo", {16'b0, rv}, 32'h1234);
        bus_rd(2'b00, rv); check("b0_iso_hi", {16'b0, rv}, 32'hABCD);
        bus_wr(2'b11, 16'h0005);
        bus_rd(2'b01, rv); check("b1_rd_status", {16'b0, rv}, 32'h01C5);
        bus_rd(2'b00, rv); check("b1_lo", {16'b0, rv}, 32'h0001);
        bus_rd(2'b00, rv); check("b1_hi", {16'b0, rv}, 32'h0000);
        check("no_err_yet", err5_cnt, 0);

        // Interrupts
        @(posedge clk); #1 evt5 = 2'b01;
        @(posedge clk); #1 evt5 = 2'b00;
        @(negedge clk);
        check("int0_set", {31'b0, b5.OTG_INT0}, 32'd1);
        check("int1_clr", {31'b0, b5.OTG_INT1}, 32'd0);
        bus_wr(2'b01, 16'h001F);
        check("int0_rdclr", {31'b0, b5.OTG_INT0}, 32'd0);
        bus_rd(2'b00, rv); check("irq_lo", {16'b0, rv}, 32'h0001);
        bus_rd(2'b00, rv); check("irq_hi", {16'b0, rv}, 32'h0000);
        bus_wr(2'b01, 16'h001F, 1'b1);
        @(negedge clk);
        check("int0_set_wins", {31'b0, b5.OTG_INT0}, 32'd1);
        bus_rd(2'b00, rv); check("irq2_lo", {16'b0, rv}, 32'h0000);
        bus_rd(2'b00, rv); check("irq2_hi", {16'b0, rv}, 32'h0000);

        // Errors
        bus_rd(2'b00, rv); check("idle_rd_data", {16'b0, rv}, 32'h0000);
        check("idle_rd_err", err5_cnt, 1);
        bus_rd(2'b01, rv); check("idle_status", {16'b0, rv}, 32'h001F);
        bus_wr(2'b01, 16'h0005);
        bus_wr(2'b00, 16'h5555);
        check("rdlo_wr_err", err5_cnt, 2);
        bus_rd(2'b01, rv); check("rdlo_wr_state", {16'b0, rv}, 32'h0185);
        bus_wr(2'b01, 16'h0085);
        bus_wr(2'b01, 16'h0003);
        bus_rd(2'b01, rv); check("abort_status", {16'b0, rv}, 32'h0183);
        check("abort_no_err", err5_cnt, 2);

        // Out of range on the 4-bit-index instance
        tgt = 1'b1;
        bus_wr(2'b01, 16'h0085);
        bus_wr(2'b00, 16'hCAFE);
        bus_wr(2'b00, 16'hBEEF);
        check("d4_we", we4_cnt, 1);
        bus_wr(2'b01, 16'h0095);
        bus_rd(2'b01, rv); check("d4_oor_status", {16'b0, rv}, 32'h0085);
        bus_wr(2'b00, 16'h1111);
        bus_wr(2'b00, 16'h2222);
        check("d4_oor_no_we", we4_cnt, 1);
        bus_wr(2'b01, 16'h0005);
        bus_rd(2'b00, rv); check("d4_keep_lo", {16'b0, rv}, 32'hCAFE);
        bus_rd(2'b00, rv); check("d4_keep_hi", {16'b0, rv}, 32'hBEEF);
        bus_wr(2'b01, 16'h0015);
        bus_rd(2'b00, rv); check("d4_oor_lo", {16'b0, rv}, 32'h0000);
        bus_rd(2'b00, rv); check("d4_oor_hi", {16'b0, rv}, 32'h0000);
        tgt = 1'b0;

        // Reset in the middle of a read in RD_HI
        bus_wr(2'b01, 16'h0005);
        bus_rd(2'b00, rv); check("pre_rst_lo", {16'b0, rv}, 32'h1234);
        @(posedge clk); #1;
        addr = 2'b00; cs_n = 1'b0; rd_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_oe", {31'b0, b5.OTG_DATA_OE}, 32'd1);
        check("pre_rst_int0", {31'b0, b5.OTG_INT0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_oe_async", {31'b0, b5.OTG_DATA_OE}, 32'd0);
        check("rst_int0_async", {31'b0, b5.OTG_INT0}, 32'd0);
        check("rst_state", {29'b0, dut5.state}, 32'd0);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        bus_rd(2'b01, rv); check("post_rst_status", {16'b0, rv}, 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/otg_bus_responder.md
Name: otg_bus_responder

Overview:
- Device-side responder for the 16-bit OTG host bus: it answers the CS_N/RD_N/WR_N/ADDR cycles that our host interface drives toward the USB controller.
- Emulates a two-bank command/data register port with 32-bit registers accessed as two 16-bit halves, plus per-bank interrupt lines.
- Used as the bus model in system simulation and as an on-chip stand-in when the external controller is absent.

Parameters:
- IDX_W, 5, index bits used per bank (2**IDX_W 32-bit registers per bank).
- IRQ_IDX, 5'h1F, per-bank read-to-clear interrupt status index.
- SYNC_STAGES, 2, synchronizer depth on CS_N/RD_N/WR_N.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous reset, active-high.
- OTG_ADDR  in  2  bit0: 1=command port, 0=data port; bit1: bank select (commands only).
- OTG_CS_N  in  1  chip select, active-low, asynchronous to iCLK.
- OTG_RD_N  in  1  read strobe, active-low.
- OTG_WR_N  in  1  write strobe, active-low.
- OTG_DATA_IN  in  16  bus write data.
- OTG_DATA_OUT  out  16  bus read data.
- OTG_DATA_OE  out  1  drive enable for OTG_DATA.
- OTG_INT0  out  1  bank-0 interrupt, active-high level.
- OTG_INT1  out  1  bank-1 interrupt, active-high level.
- iEVT  in  2  per-bank event pulses (1 cycle) that set the pending flag.
- oREG_WE  out  1  1-cycle pulse on each committed 32-bit register write.
- oREG_BANK  out  1  bank of the committed write.
- oREG_IDX  out  IDX_W  index of the committed write.
- oREG_WDATA  out  32  data of the committed write.
- oERR  out  1  1-cycle pulse on a protocol error.

Behaviour:
- Reset: all outputs 0, regfile 0, FSM in IDLE, bank/index 0, pending flags 0.
- Sync: CS_N, RD_N and WR_N pass through SYNC_STAGES FFs.
  - Access active = sync CS low AND (RD or WR) low.
  - While a write is active, ADDR/DATA_IN are captured every cycle. The access commits on its trailing edge (first sync cycle where strobe or CS goes high), using the last captured values.
  - Host requirements: strobe low ≥ SYNC_STAGES+2 clocks; ADDR/DATA stable while strobe low.
  - Both RD and WR low together: treat as an error; pulse oERR at trailing edge, no state change.
- Command write (ADDR[0]=1):
  - bank←ADDR[1], idx←DATA[IDX_W-1:0].
  - DATA[7]=1 → state WR_LO.
  - DATA[7]=0 → latch rdbuf←reg[bank][idx] (or {31'b0,pend[bank]} when idx==IRQ_IDX), state RD_LO; if idx==IRQ_IDX, pend[bank] is cleared on the same commit.
  - DATA[6:IDX_W] nonzero → index out of range: writes dropped, reads return 0.
  - A command in any state aborts the pending sequence without error.
- Data write (ADDR[0]=0, ADDR[1] ignored):
  - WR_LO: lo←DATA, go to WR_HI.
  - WR_HI: commit reg[bank][idx]←{DATA,lo}; pulse oREG_WE/BANK/IDX/WDATA in the commit cycle; go to IDLE.
  - Writes to IRQ_IDX are not stored but still pulse oREG_WE.
  - In IDLE, RD_LO or RD_HI: ignored, oERR pulse.
- Data read:
  - OTG_DATA_OE=1 from the first cycle the sync read is active until trailing edge+1.
  - OTG_DATA_OUT = rdbuf[15:0] in RD_LO, rdbuf[31:16] in RD_HI. It advances RD_LO→RD_HI→IDLE at each trailing edge.
  - Read in another state: returns 16'h0000, oERR pulse, no state change.
- Command read: returns {6'b0, state[2:0], bank, 1'b0, idx zero-extended to 5 bits}; state code IDLE=0, WR_LO=1, WR_HI=2, RD_LO=3, RD_HI=4.
- Interrupts: pend[b] set by iEVT[b]; OTG_INTb = pend[b], registered. Set and read-clear in the same cycle → set wins.
- Reset mid-access: immediate return to reset values; OE deasserts asynchronously.

Test Plan:
- Write sequence: cmd 0x85 on bank 0, data 0x1234 then 0xABCD.
  - oREG_WE pulses once with IDX=5, WDATA=0xABCD1234.
  - Readback via cmd 0x05 returns 0x1234 then 0xABCD; state ends IDLE.
- Bank isolation: write 0x0000_0001 to bank1 idx5; bank0 idx5 still reads 0xABCD1234.
- Interrupt:
  - iEVT=2'b01 → OTG_INT0=1, INT1=0.
  - cmd 0x1F on bank 0 then two reads → 0x0001, 0x0000, INT0=0.
  - iEVT[0] in the clear-commit cycle → INT0 stays 1.
- Errors:
  - Data read in IDLE → 0x0000 and oERR.
  - Data write in RD_LO → oERR, state stays 3.
  - Cmd 0x85 then cmd 0x03 → state RD_LO, no oERR.
- Out of range (IDX_W=4):
  - cmd 0x95 plus two data writes → no regfile change.
  - Reads of idx 0x15 → 0x0000, 0x0000.
- Reset asserted with RD low in RD_HI → OE=0 and state IDLE at once; after release, cmd read returns 0x0000.
